// File: rtl/test_din_sink.sv
// ----------------------------------------------------------------------------
// test_din_sink
//
// Streaming input sink and statistics collector. Every cycle with din_valid
// high consumes one unsigned DWIDTH-bit sample (there is no back-pressure)
// and folds it into a set of registered accumulators covering the samples
// accepted since the last reset or stat_clear.
//
// Parameters
//   DWIDTH      sample width in bits (unsigned samples)
//   CWIDTH      width of the saturating sample counter
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din_valid   din_data carries a sample this cycle
//   din_data    sample value
//   stat_clear  synchronous clear; a sample in the same cycle is counted
//               as the first sample after the clear
//   stat_cnt    accepted-sample count, saturating at all-ones
//   stat_sum    running sum, wraps modulo 2^(DWIDTH+CWIDTH)
//   stat_min    smallest accepted sample (all-ones when empty)
//   stat_max    largest accepted sample (zero when empty)
//   stat_last   most recently accepted sample
//   stat_empty  high while stat_cnt is zero
//   stat_ovf    sticky: a sample arrived while stat_cnt was all-ones
//   stat_crc    running CRC-16-CCITT over accepted samples
//
// Build option
//   TEST_DIN_CRC_EN  when defined, stat_crc is a CRC-16-CCITT (poly 0x1021,
//                    init 0xFFFF, MSB first, no reflection, no final XOR)
//                    over all DWIDTH bits of each sample in one cycle.
//                    When undefined, no CRC logic exists and stat_crc = 0.
// ----------------------------------------------------------------------------
module test_din_sink #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_valid,
    input  logic [DWIDTH-1:0]        din_data,
    input  logic                     stat_clear,
    output logic [CWIDTH-1:0]        stat_cnt,
    output logic [DWIDTH+CWIDTH-1:0] stat_sum,
    output logic [DWIDTH-1:0]        stat_min,
    output logic [DWIDTH-1:0]        stat_max,
    output logic [DWIDTH-1:0]        stat_last,
    output logic                     stat_empty,
    output logic                     stat_ovf,
    output logic [15:0]              stat_crc
);

    localparam int SWIDTH = DWIDTH + CWIDTH;

    // Saturating increment: holds at all-ones.
    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CWIDTH-1){1'b0}}, 1'b1};
    endfunction

`ifdef TEST_DIN_CRC_EN
    // One sample through CRC-16-CCITT, MSB first, fully unrolled.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [DWIDTH-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    // Accumulator registers
    logic [CWIDTH-1:0] cnt_p1;
    logic [SWIDTH-1:0] sum_p1;
    logic [DWIDTH-1:0] min_p1;
    logic [DWIDTH-1:0] max_p1;
    logic [DWIDTH-1:0] last_p1;
    logic              ovf_p1;

    // Next-state values
    logic [CWIDTH-1:0] cnt_base,  cnt_nxt;
    logic [SWIDTH-1:0] sum_base,  sum_nxt;
    logic [DWIDTH-1:0] min_base,  min_nxt;
    logic [DWIDTH-1:0] max_base,  max_nxt;
    logic [DWIDTH-1:0] last_base, last_nxt;
    logic              ovf_base,  ovf_nxt;

    // Input stage -> accumulators. Clear selects the reset values as the
    // starting point, so a same-cycle sample lands on a fresh state.
    always_comb begin
        cnt_base  = stat_clear ? '0 : cnt_p1;
        sum_base  = stat_clear ? '0 : sum_p1;
        min_base  = stat_clear ? '1 : min_p1;
        max_base  = stat_clear ? '0 : max_p1;
        last_base = stat_clear ? '0 : last_p1;
        ovf_base  = stat_clear ? 1'b0 : ovf_p1;

        cnt_nxt  = cnt_base;
        sum_nxt  = sum_base;
        min_nxt  = min_base;
        max_nxt  = max_base;
        last_nxt = last_base;
        ovf_nxt  = ovf_base;

        if (din_valid) begin
            cnt_nxt  = sat_inc(cnt_base);
            ovf_nxt  = ovf_base | (&cnt_base);
            sum_nxt  = sum_base + {{CWIDTH{1'b0}}, din_data};
            min_nxt  = (din_data < min_base) ? din_data : min_base;
            max_nxt  = (din_data > max_base) ? din_data : max_base;
            last_nxt = din_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1  <= '0;
            sum_p1  <= '0;
            min_p1  <= '1;
            max_p1  <= '0;
            last_p1 <= '0;
            ovf_p1  <= 1'b0;
        end else begin
            cnt_p1  <= cnt_nxt;
            sum_p1  <= sum_nxt;
            min_p1  <= min_nxt;
            max_p1  <= max_nxt;
            last_p1 <= last_nxt;
            ovf_p1  <= ovf_nxt;
        end
    end

`ifdef TEST_DIN_CRC_EN
    logic [15:0] crc_p1;
    logic [15:0] crc_base, crc_nxt;

    always_comb begin
        crc_base = stat_clear ? 16'hFFFF : crc_p1;
        crc_nxt  = crc_base;
        if (din_valid) begin
            crc_nxt = crc16_step(crc_base, din_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_p1 <= 16'hFFFF;
        end else begin
            crc_p1 <= crc_nxt;
        end
    end

    assign stat_crc = crc_p1;
`else
    assign stat_crc = 16'h0000;
`endif

    assign stat_cnt   = cnt_p1;
    assign stat_sum   = sum_p1;
    assign stat_min   = min_p1;
    assign stat_max   = max_p1;
    assign stat_last  = last_p1;
    assign stat_ovf   = ovf_p1;
    assign stat_empty = (cnt_p1 == '0);

endmodule

// File: tb/tb_test_din_sink.sv
// ----------------------------------------------------------------------------
// tb_test_din_sink
//
// Drives two instances of test_din_sink: a default-width one for the main
// statistics and CRC behaviour, and a CWIDTH=4 one for counter saturation.
// The reference model keeps the list of samples accepted since the last
// reset/clear and derives every statistic from that list directly.
// ----------------------------------------------------------------------------
module tb_test_din_sink;

    localparam int DW  = 16;
    localparam int CW  = 32;
    localparam int SCW = 4;

    logic clk;
    logic rst_n;

    // Main instance
    logic           din_valid;
    logic [DW-1:0]  din_data;
    logic           stat_clear;
    logic [CW-1:0]  stat_cnt;
    logic [DW+CW-1:0] stat_sum;
    logic [DW-1:0]  stat_min;
    logic [DW-1:0]  stat_max;
    logic [DW-1:0]  stat_last;
    logic           stat_empty;
    logic           stat_ovf;
    logic [15:0]    stat_crc;

    // Saturation instance
    logic             s_valid;
    logic [DW-1:0]    s_data;
    logic             s_clear;
    logic [SCW-1:0]   s_cnt;
    logic [DW+SCW-1:0] s_sum;
    logic [DW-1:0]    s_min;
    logic [DW-1:0]    s_max;
    logic [DW-1:0]    s_last;
    logic             s_empty;
    logic             s_ovf;
    logic [15:0]      s_crc;

    int checks   = 0;
    int failures = 0;

    // Samples accepted since the last reset/clear
    logic [DW-1:0] acc[$];
    logic [DW-1:0] sacc[$];

    test_din_sink #(.DWIDTH(DW), .CWIDTH(CW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_data   (din_data),
        .stat_clear (stat_clear),
        .stat_cnt   (stat_cnt),
        .stat_sum   (stat_sum),
        .stat_min   (stat_min),
        .stat_max   (stat_max),
        .stat_last  (stat_last),
        .stat_empty (stat_empty),
        .stat_ovf   (stat_ovf),
        .stat_crc   (stat_crc)
    );

    test_din_sink #(.DWIDTH(DW), .CWIDTH(SCW)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (s_valid),
        .din_data   (s_data),
        .stat_clear (s_clear),
        .stat_cnt   (s_cnt),
        .stat_sum   (s_sum),
        .stat_min   (s_min),
        .stat_max   (s_max),
        .stat_last  (s_last),
        .stat_empty (s_empty),
        .stat_ovf   (s_ovf),
        .stat_crc   (s_crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // CRC-16-CCITT computed bytewise (high byte first) over a sample list.
    function automatic logic [15:0] crc_of(input logic [DW-1:0] q[$]);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        foreach (q[k]) begin
            for (int j = 1; j >= 0; j--) begin
                b = q[k][j*8 +: 8];
                c = c ^ {b, 8'h00};
                for (int n = 0; n < 8; n++) begin
                    c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
                end
            end
        end
        return c;
    endfunction

    // Compare one instance's outputs with statistics derived from its list.
    task automatic check_set(input string tag, input logic [DW-1:0] q[$], input int cw,
                             input logic [63:0] cnt, input logic [63:0] sum,
                             input logic [DW-1:0] mn, input logic [DW-1:0] mx,
                             input logic [DW-1:0] last, input logic empty,
                             input logic ovf, input logic [15:0] crc);
        longint unsigned e_cnt, e_sum, cmax, smask;
        logic [DW-1:0]   e_min, e_max, e_last;
        cmax  = (64'd1 << cw) - 1;
        smask = (64'd1 << (cw + DW)) - 1;
        e_cnt = (q.size() > cmax) ? cmax : longint'(q.size());
        e_sum = 0;
        e_min = '1;
        e_max = '0;
        foreach (q[k]) begin
            e_sum = e_sum + q[k];
            if (q[k] < e_min) e_min = q[k];
            if (q[k] > e_max) e_max = q[k];
        end
        e_sum  = e_sum & smask;
        e_last = (q.size() > 0) ? q[q.size()-1] : '0;
        check({tag, "_cnt"},   cnt,   e_cnt);
        check({tag, "_sum"},   sum,   e_sum);
        check({tag, "_min"},   64'(mn),   64'(e_min));
        check({tag, "_max"},   64'(mx),   64'(e_max));
        check({tag, "_last"},  64'(last), 64'(e_last));
        check({tag, "_empty"}, 64'(empty), 64'(q.size() == 0));
        check({tag, "_ovf"},   64'(ovf),   64'(q.size() > cmax));
`ifdef TEST_DIN_CRC_EN
        check({tag, "_crc"},   64'(crc),   64'(crc_of(q)));
`else
        check({tag, "_crc"},   64'(crc),   64'h0);
`endif
    endtask

    task automatic check_all(input string tag);
        check_set({tag, "_m"}, acc, CW, 64'(stat_cnt), 64'(stat_sum), stat_min, stat_max,
                  stat_last, stat_empty, stat_ovf, stat_crc);
        check_set({tag, "_s"}, sacc, SCW, 64'(s_cnt), 64'(s_sum), s_min, s_max,
                  s_last, s_empty, s_ovf, s_crc);
    endtask

    // One clock of stimulus on both instances; model updates at the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic c,
                        input logic sv, input logic [DW-1:0] sd, input logic sc);
        din_valid  = v;  din_data = d;  stat_clear = c;
        s_valid    = sv; s_data   = sd; s_clear    = sc;
        @(posedge clk);
        if (c)  acc.delete();
        if (v)  acc.push_back(d);
        if (sc) sacc.delete();
        if (sv) sacc.push_back(sd);
        #1;
    endtask

    task automatic main_step(input logic v, input logic [DW-1:0] d, input logic c);
        step(v, d, c, 1'b0, '0, 1'b0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        acc.delete();
        sacc.delete();
        #2;
    endtask

    logic [DW-1:0] rd;

    initial begin
        rst_n = 1'b0;
        din_valid = 0; din_data = '0; stat_clear = 0;
        s_valid = 0; s_data = '0; s_clear = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check_all("rst_low");
        rst_n = 1'b1;
        main_step(0, '0, 0);
        check_all("rst_rel");
        check("rst_min_const", 64'(stat_min), 64'hFFFF);
`ifdef TEST_DIN_CRC_EN
        check("rst_crc_const", 64'(stat_crc), 64'hFFFF);
`else
        check("rst_crc_const", 64'(stat_crc), 64'h0);
`endif

        // Back-to-back stream
        main_step(1, 16'd5, 0);     check_all("b2b0");
        main_step(1, 16'd300, 0);   check_all("b2b1");
        main_step(1, 16'd2, 0);     check_all("b2b2");
        main_step(1, 16'd65535, 0); check_all("b2b3");
        check("b2b_cnt_const",  64'(stat_cnt), 64'd4);
        check("b2b_sum_const",  64'(stat_sum), 64'd65842);
        check("b2b_min_const",  64'(stat_min), 64'd2);
        check("b2b_max_const",  64'(stat_max), 64'd65535);
        check("b2b_last_const", 64'(stat_last), 64'd65535);

        // Gapped valid after a plain clear
        main_step(0, '0, 1);        check_all("clr");
        main_step(1, 16'd10, 0);
        main_step(0, 16'd99, 0);
        main_step(1, 16'd20, 0);    check_all("gap");
        check("gap_cnt_const",  64'(stat_cnt), 64'd2);
        check("gap_sum_const",  64'(stat_sum), 64'd30);
        check("gap_max_const",  64'(stat_max), 64'd20);
        check("gap_last_const", 64'(stat_last), 64'd20);

        // Clear with sample in the same cycle
        main_step(1, 16'd7, 1);     check_all("clrs");
        check("clrs_cnt_const", 64'(stat_cnt), 64'd1);
        check("clrs_sum_const", 64'(stat_sum), 64'd7);
        check("clrs_min_const", 64'(stat_min), 64'd7);
        check("clrs_ovf_const", 64'(stat_ovf), 64'd0);

        // Single-sample CRC after reset
        async_reset();
        @(negedge clk);
        rst_n = 1'b1;
        main_step(1, 16'h1234, 0);  check_all("crc1");
`ifdef TEST_DIN_CRC_EN
        check("crc1_const", 64'(stat_crc), 64'h0EC9);
`endif

        // Mid-stream asynchronous reset; samples during reset are dropped
        for (int i = 0; i < 6; i++) begin
            main_step(1, 16'($urandom), 0);
        end
        async_reset();
        check_all("arst");
        din_valid = 1'b1; din_data = 16'h5A5A;
        @(posedge clk);
        #1;
        check_all("arst_hold");
        rst_n = 1'b1;
        main_step(0, '0, 0);        check_all("arst_rel");

        // Randomized stream with occasional clears and extreme values
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       rd = '0;
                1:       rd = '1;
                default: rd = 16'($urandom);
            endcase
            main_step($urandom_range(0, 9) < 7, rd, $urandom_range(0, 39) == 0);
            check_all($sformatf("rnd%0d", i));
        end

        // Counter saturation on the CWIDTH=4 instance
        step(0, '0, 0, 0, '0, 1);
        for (int i = 0; i < 17; i++) begin
            step(0, '0, 0, 1, 16'($urandom_range(0, 1000)), 0);
            check_all($sformatf("sat%0d", i));
        end
        check("sat_cnt_const", 64'(s_cnt), 64'd15);
        check("sat_ovf_const", 64'(s_ovf), 64'd1);
        step(0, '0, 0, 0, '0, 0);
        step(0, '0, 0, 1, 16'd3, 0);
        check_all("sat_hold");
        check("sat_ovf_sticky", 64'(s_ovf), 64'd1);
        step(0, '0, 0, 0, '0, 1);
        check_all("sat_clr");
        check("sat_ovf_clr", 64'(s_ovf), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/test_din_sink.md
# test_din_sink

Streaming input sink and statistics collector for a single valid-qualified data bus. It accepts one DWIDTH-bit unsigned sample on every cycle where din_valid is high and keeps running statistics over the samples accepted since the last reset or clear: count, sum, minimum, maximum, last value and an optional CRC. It sits at the end of a data path as a checker or monitor endpoint. It never stalls: there is no ready signal, and every valid sample is consumed.

## Interface
- DWIDTH, 16, sample width in bits; samples are unsigned
- CWIDTH, 32, width of the sample counter
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- din_valid  input  1  din_data holds a sample to accept this cycle
- din_data  input  DWIDTH  sample value
- stat_clear  input  1  synchronous clear of all statistics
- stat_cnt  output  CWIDTH  number of accepted samples; saturates
- stat_sum  output  DWIDTH+CWIDTH  running sum of accepted samples; wraps modulo 2^(DWIDTH+CWIDTH)
- stat_min  output  DWIDTH  smallest accepted sample
- stat_max  output  DWIDTH  largest accepted sample
- stat_last  output  DWIDTH  most recently accepted sample
- stat_empty  output  1  high when stat_cnt == 0
- stat_ovf  output  1  sticky; set when a sample arrives while stat_cnt is already all-ones
- stat_crc  output  16  running CRC over accepted samples

## Operation
- A sample is accepted on each rising clk edge where din_valid = 1. din_data is ignored when din_valid = 0.
- On an accepted sample:
  - stat_cnt increments; at all-ones it holds and stat_ovf is set.
  - stat_sum += din_data, zero-extended before the add.
  - stat_min = min(stat_min, din_data).
  - stat_max = max(stat_max, din_data).
  - stat_last = din_data.
  - stat_crc is updated.
- Clear (stat_clear = 1) returns every statistic to its reset value.
- Clear and din_valid in the same cycle: the clear applies first, then the sample is accepted. The result is stat_cnt = 1 with min = max = last = sum = din_data, and the CRC restarted from init and advanced by that sample.
- Comparisons for min and max are unsigned.
- No internal state machine; the block is a set of registered accumulators.

## Timing
- All outputs are registered. A sample accepted at edge N is visible on the outputs after edge N; there is no further latency.
- Samples may arrive back-to-back on every cycle with no throughput limit.
- Reset values:
  - stat_cnt = 0, stat_sum = 0, stat_last = 0
  - stat_min = all-ones, stat_max = 0
  - stat_empty = 1, stat_ovf = 0, stat_crc = 16'hFFFF
- Reset asserted mid-stream: all state returns to its reset values immediately, asynchronously. Samples present during reset are discarded.
- stat_empty is derived from the registered count, so it falls in the same cycle stat_cnt becomes 1.
- stat_ovf clears only on reset or stat_clear.

## Configuration
- Macro TEST_DIN_CRC_EN.
- When defined: stat_crc is a CRC-16-CCITT running checksum.
  - Polynomial 0x1021, init 16'hFFFF, no reflection, no final XOR.
  - Each accepted sample is processed MSB first, all DWIDTH bits in one cycle; the combinational unroll lives in a function.
- When not defined: no CRC logic is built and stat_crc is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset check: hold rst_n low, then release with no valid input -> stat_cnt = 0, stat_empty = 1, stat_min = 16'hFFFF, stat_max = 0, stat_crc = 16'hFFFF (macro defined) or 16'h0000 (macro undefined).
- Back-to-back stream: samples 5, 300, 2, 65535 on four consecutive cycles -> stat_cnt = 4, stat_sum = 65842, stat_min = 2, stat_max = 65535, stat_last = 65535, each output updated one edge after its sample.
- Gapped valid: din_valid toggles 1,0,1 with din_data = 10, 99, 20 -> stat_cnt = 2, stat_sum = 30; the value 99 does not affect min, max or last.
- Clear with sample: in the same cycle as stat_clear, present din_valid = 1 and din_data = 7 -> stat_cnt = 1, stat_sum = 7, stat_min = stat_max = stat_last = 7, stat_ovf = 0.
- Counter saturation: with CWIDTH = 4, send 17 samples -> stat_cnt holds at 15, stat_ovf = 1; stat_ovf returns to 0 only after stat_clear.
- CRC (macro defined): single sample 16'h1234 after reset -> stat_crc equals the CRC-16-CCITT of bytes 0x12, 0x34 with init 0xFFFF (0x0EC9). Asserting rst_n low mid-stream -> stat_crc returns to 16'hFFFF.
